// File: rtl/mem_access_if.sv
// mem_access_if: request/acknowledge data bus between the MEM stage and data memory
interface mem_access_if;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        ack;

    modport master (output req, we, addr, be, wdata, input rdata, ack);
    modport slave  (input req, we, addr, be, wdata, output rdata, ack);
endinterface

// File: rtl/mem_access.sv
// mem_access: RV32I MEM stage; runs loads/stores on a req/ack bus and registers the write-back bundle
module mem_access #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 5
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [2:0]   alusel_i,
    input  logic [6:0]   aluop_i,
    input  logic [31:0]  mem_addr_i,
    input  logic [31:0]  r2_i,
    input  logic [31:0]  wdata_i,
    input  logic [4:0]   waddr_i,
    input  logic         wvalid_i,
    output logic         stall_o,
    mem_access_if.master dbus,
    output logic         wvalid_o,
    output logic [4:0]   waddr_o,
    output logic [31:0]  wdata_o,
    output logic         misalign_o,
    output logic         buserr_o
);
    // Op encodings shared with EX; any memory aluop not listed is treated as a word access.
    localparam logic [2:0] ALU_LOAD  = 3'b100;
    localparam logic [2:0] ALU_STORE = 3'b101;
    localparam logic [6:0] OP_LB     = 7'h01;
    localparam logic [6:0] OP_LH     = 7'h02;
    localparam logic [6:0] OP_LBU    = 7'h04;
    localparam logic [6:0] OP_LHU    = 7'h05;
    localparam logic [6:0] OP_SB     = 7'h08;
    localparam logic [6:0] OP_SH     = 7'h09;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t           state, state_n;
    logic [CNT_W-1:0] cnt;
    logic [6:0]       lat_op;
    logic [1:0]       lat_a;
    logic [4:0]       lat_waddr;
    logic             lat_wvalid;
    logic             lat_st;
    logic             issue, done, tmo, mis;
    logic             is_st, is_mem, is_b, is_h, aligned;
    logic [1:0]       a;
    logic [3:0]       be_c;
    logic [31:0]      wd_c, lane, ld_val;

    assign a       = mem_addr_i[1:0];
    assign is_st   = alusel_i == ALU_STORE;
    assign is_mem  = alusel_i == ALU_LOAD || is_st;
    assign is_b    = aluop_i == OP_LB || aluop_i == OP_LBU || aluop_i == OP_SB;
    assign is_h    = aluop_i == OP_LH || aluop_i == OP_LHU || aluop_i == OP_SH;
    assign aligned = is_b ? 1'b1 : is_h ? !a[0] : a == 2'b00;
    assign be_c    = is_b ? 4'b0001 << a : is_h ? 4'b0011 << a : 4'hF;
    assign wd_c    = is_b ? {4{r2_i[7:0]}} : is_h ? {2{r2_i[15:0]}} : r2_i;
    assign lane    = dbus.rdata >> {lat_a, 3'b000};
    assign ld_val  = lat_op == OP_LB  ? {{24{lane[7]}}, lane[7:0]} :
                     lat_op == OP_LBU ? {24'b0, lane[7:0]} :
                     lat_op == OP_LH  ? {{16{lane[15]}}, lane[15:0]} :
                     lat_op == OP_LHU ? {16'b0, lane[15:0]} : lane;

    // Next state plus the per-cycle issue/complete/timeout/misalign decisions and the stall.
    always_comb begin
        state_n = state;
        stall_o = 1'b0;
        issue   = 1'b0;
        done    = 1'b0;
        tmo     = 1'b0;
        mis     = 1'b0;
        if (state == IDLE) begin
            issue   = is_mem && aligned;
            mis     = is_mem && !aligned;
            stall_o = issue;
            state_n = issue ? BUSY : IDLE;
        end else begin
            done    = dbus.ack;
            tmo     = !dbus.ack && cnt == CNT_W'(TIMEOUT - 1);
            stall_o = !(done || tmo);
            state_n = (done || tmo) ? IDLE : BUSY;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    // Bus drive, access context latch, timeout counter and write-back bundle.
    always_ff @(posedge clk) begin
        if (rst) begin
            dbus.req   <= 1'b0;
            dbus.we    <= 1'b0;
            dbus.addr  <= '0;
            dbus.be    <= '0;
            dbus.wdata <= '0;
            cnt        <= '0;
            lat_op     <= '0;
            lat_a      <= '0;
            lat_waddr  <= '0;
            lat_wvalid <= 1'b0;
            lat_st     <= 1'b0;
            wvalid_o   <= 1'b0;
            waddr_o    <= '0;
            wdata_o    <= '0;
            misalign_o <= 1'b0;
            buserr_o   <= 1'b0;
        end else begin
            misalign_o <= mis;
            buserr_o   <= tmo;
            cnt        <= (state == BUSY && !done && !tmo) ? cnt + 1'b1 : '0;
            if (issue) begin
                dbus.req   <= 1'b1;
                dbus.we    <= is_st;
                dbus.addr  <= {mem_addr_i[31:2], 2'b00};
                dbus.be    <= be_c;
                dbus.wdata <= is_st ? wd_c : '0;
                lat_op     <= aluop_i;
                lat_a      <= a;
                lat_waddr  <= waddr_i;
                lat_wvalid <= wvalid_i;
                lat_st     <= is_st;
                wvalid_o   <= 1'b0;
            end else if (done || tmo) begin
                dbus.req <= 1'b0;
                wvalid_o <= done && !lat_st && lat_wvalid;
                if (done && !lat_st) begin
                    waddr_o <= lat_waddr;
                    wdata_o <= ld_val;
                end
            end else if (state == IDLE) begin
                wvalid_o <= !is_mem && wvalid_i;
                if (!is_mem) begin
                    waddr_o <= waddr_i;
                    wdata_o <= wdata_i;
                end
            end
        end
    end
endmodule
